// File: rtl/lut_interpolator.sv
// Two-stage piecewise-linear interpolator driving the activation LUT read port.
// Optional macro LUT_INTERP_ROUND_EN selects round-half-up instead of floor.
module lut_interpolator #(
    parameter int ADDR_W = 4,
    parameter int FRAC_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W+FRAC_W-1:0] in_x,
    output logic [ADDR_W-1:0]        lut_address,
    input  logic [DATA_W-1:0]        lut_base,
    input  logic [DATA_W-1:0]        lut_next,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_y
);
    localparam int IN_W   = ADDR_W + FRAC_W;
    localparam int PROD_W = DATA_W + FRAC_W + 2;

    logic              adv, accept;
    logic [2:1]        vld_pipe;   // [1] = S1 valid, [2] = output valid
    logic [FRAC_W-1:0] s1_frac;

    assign adv       = !vld_pipe[2] || out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid && adv;
    assign out_valid = vld_pipe[2];

    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_x, frac_x, base_x, prod, prod_r, shifted;

    assign diff   = $signed({lut_next[DATA_W-1], lut_next}) - $signed({lut_base[DATA_W-1], lut_base});
    assign diff_x = {{(PROD_W-DATA_W-1){diff[DATA_W]}}, diff};
    assign frac_x = {{(PROD_W-FRAC_W){1'b0}}, s1_frac};
    assign base_x = {{(PROD_W-DATA_W){lut_base[DATA_W-1]}}, lut_base};
    assign prod   = diff_x * frac_x;

`ifdef LUT_INTERP_ROUND_EN
    assign prod_r = prod + (PROD_W'(1) <<< (FRAC_W-1));
`else
    assign prod_r = prod;
`endif
    // Arithmetic shift floors; the sum stays between base and next, so truncation is exact.
    assign shifted = prod_r >>> FRAC_W;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe    <= '0;
            lut_address <= '0;
            s1_frac     <= '0;
            out_y       <= '0;
        end else if (adv) begin
            vld_pipe[1] <= accept;
            vld_pipe[2] <= vld_pipe[1];
            if (accept) begin
                lut_address <= in_x[IN_W-1:FRAC_W];
                s1_frac     <= in_x[FRAC_W-1:0];
            end
            if (vld_pipe[1])
                out_y <= DATA_W'(base_x + shifted);
        end
    end
endmodule

// File: tb/tb_lut_interpolator.sv
// Directed bench for lut_interpolator: LUT model lut[i]=16*i (i<8), 0 otherwise, plus a stub LUT.
module tb_lut_interpolator;
    logic       clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic [7:0] in_x = '0;
    logic       in_ready, out_valid;
    logic [3:0] lut_address;
    logic [7:0] lut_base, lut_next, out_y;
    logic       stub_en = 0;
    logic [7:0] stub_base = '0, stub_next = '0;
    int checks = 0, failures = 0;

    lut_interpolator #(.ADDR_W(4), .FRAC_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .lut_address(lut_address), .lut_base(lut_base), .lut_next(lut_next),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y));

    always #5 clk = ~clk;

    function automatic int lutv(input int a);
        return (a < 8) ? a * 16 : 0;
    endfunction

    always_comb begin
        lut_base = stub_base;
        lut_next = stub_next;
        if (!stub_en) begin
            lut_base = 8'(lutv(int'(lut_address)));
            lut_next = (lut_address == 4'd7) ? lut_base : 8'(lutv((int'(lut_address) + 1) % 16));
        end
    end

    function automatic logic [7:0] model(input logic [7:0] x);
        int a, f, b, n, p;
        a = int'(x[7:4]);
        f = int'(x[3:0]);
        b = lutv(a);
        n = (a == 7) ? b : lutv((a + 1) % 16);
        p = (n - b) * f;
`ifdef LUT_INTERP_ROUND_EN
        p = p + 8;
`endif
        return 8'(b + (p >>> 4));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (lut_address !== 4'd0) begin failures++; $display("FAIL reset_lut_address got=%0d exp=0", lut_address); end
        checks++; if (out_y !== 8'd0) begin failures++; $display("FAIL reset_out_y got=%0d exp=0", out_y); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_interp();
        logic [7:0] xs [3];
        logic [7:0] ys [3];
        xs = '{8'h25, 8'h7F, 8'hF8};
        ys = '{8'd37, 8'd112, 8'd0};
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_x = xs[i]; in_valid = 1;
            tick();
            in_valid = 0;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL interp_early x=%h got=%b exp=0", xs[i], out_valid); end
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL interp_valid x=%h got=%b exp=1", xs[i], out_valid); end
            checks++; if (out_y !== ys[i]) begin failures++; $display("FAIL interp_y x=%h got=%0d exp=%0d", xs[i], out_y, ys[i]); end
            tick();
        end
    endtask

    task automatic test_round();
        logic [7:0] b [2];
        logic [7:0] n [2];
        logic [7:0] e [2];
        b = '{8'd10, 8'd0};
        n = '{8'd3, 8'd5};
`ifdef LUT_INTERP_ROUND_EN
        e = '{8'd7, 8'd3};
`else
        e = '{8'd6, 8'd2};
`endif
        stub_en = 1;
        for (int i = 0; i < 2; i++) begin
            stub_base = b[i]; stub_next = n[i];
            in_x = 8'h08; in_valid = 1;
            tick();
            in_valid = 0;
            tick();
            checks++; if (out_valid !== 1'b1 || out_y !== e[i]) begin failures++; $display("FAIL round_y base=%0d next=%0d got=%0d/%b exp=%0d/1", b[i], n[i], out_y, out_valid, e[i]); end
            tick();
        end
        stub_en = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] xs [4];
        logic [7:0] ys [4];
        xs = '{8'h13, 8'h25, 8'h3A, 8'h41};
        ys = '{8'd19, 8'd37, 8'd58, 8'd65};
        out_ready = 1;
        in_valid = 1; in_x = xs[0];
        tick();
        in_x = xs[1];
        tick();
        checks++; if (out_valid !== 1'b1 || out_y !== ys[0]) begin failures++; $display("FAIL b2b_first got=%0d/%b exp=%0d/1", out_y, out_valid, ys[0]); end
        out_ready = 0; in_x = xs[2];
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_drop got=%b exp=0", in_ready); end
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_y !== ys[0]) begin failures++; $display("FAIL b2b_stall_y cyc=%0d got=%0d/%b exp=%0d/1", s, out_y, out_valid, ys[0]); end
            checks++; if (lut_address !== 4'd2) begin failures++; $display("FAIL b2b_stall_addr cyc=%0d got=%0d exp=2", s, lut_address); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready cyc=%0d got=%b exp=0", s, in_ready); end
        end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_back got=%b exp=1", in_ready); end
        for (int k = 1; k < 4; k++) begin
            tick();
            if (k == 1) in_x = xs[3];
            if (k == 2) in_valid = 0;
            checks++; if (out_valid !== 1'b1 || out_y !== ys[k]) begin failures++; $display("FAIL b2b_result idx=%0d got=%0d/%b exp=%0d/1", k, out_y, out_valid, ys[k]); end
        end
        in_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1;
        in_valid = 1; in_x = 8'h25;
        tick();
        in_x = 8'h41;
        tick();
        in_valid = 0;
        rst = 1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (lut_address !== 4'd0) begin failures++; $display("FAIL rstmid_addr got=%0d exp=0", lut_address); end
        checks++; if (out_y !== 8'd0) begin failures++; $display("FAIL rstmid_out_y got=%0d exp=0", out_y); end
        tick();
        rst = 0;
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale cyc=%0d got=%b exp=0", s, out_valid); end
        end
        in_valid = 1; in_x = 8'h13;
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_early got=%b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_y !== 8'd19) begin failures++; $display("FAIL rstmid_latency got=%0d/%b exp=19/1", out_y, out_valid); end
        tick();
    endtask

    task automatic test_random();
        localparam int N = 24;
        logic [7:0] q[$];
        logic [7:0] x, e;
        int got = 0;
        out_ready = 1;
        for (int i = 0; i < N + 4; i++) begin
            if (i < N) begin
                x = 8'($urandom_range(0, 255));
                in_valid = 1; in_x = x;
                q.push_back(model(x));
            end else begin
                in_valid = 0;
            end
            tick();
            if (i >= 1 && i <= N) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rand_throughput cyc=%0d got=%b exp=1", i, out_valid); end
            end
            if (out_valid === 1'b1) begin
                got++;
                if (q.size() == 0) begin
                    checks++; failures++; $display("FAIL rand_extra got=%0d exp=none", out_y);
                end else begin
                    e = q.pop_front();
                    checks++; if (out_y !== e) begin failures++; $display("FAIL rand_y n=%0d got=%0d exp=%0d", got, out_y, e); end
                end
            end
        end
        checks++; if (got != N) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got, N); end
    endtask

    initial begin
        test_reset();
        test_interp();
        test_round();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
